// File: rtl/mcpu_alu_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mcpu_alu_sequencer                                                         |
// | Issues register-file operands to the external MCPU ALU and writes back.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mcpu_alu_sequencer #(
    parameter int CMD_SIZE  = 2,
    parameter int WORD_SIZE = 2,
    parameter int REG_ADDR  = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic                 instr_load,
    input  logic [CMD_SIZE-1:0]  instr_op,
    input  logic [REG_ADDR-1:0]  instr_rd,
    input  logic [REG_ADDR-1:0]  instr_rs1,
    input  logic [REG_ADDR-1:0]  instr_rs2,
    input  logic [WORD_SIZE-1:0] instr_imm,
    output logic [CMD_SIZE-1:0]  alu_opcode,
    output logic [WORD_SIZE-1:0] alu_r1,
    output logic [WORD_SIZE-1:0] alu_r2,
    input  logic [WORD_SIZE-1:0] alu_out,
    input  logic                 alu_ovf,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WORD_SIZE-1:0] rsp_data,
    output logic                 rsp_ovf,
    input  logic [REG_ADDR-1:0]  dbg_addr,
    output logic [WORD_SIZE-1:0] dbg_data
);

    localparam int                  c_nregs   = 2 ** REG_ADDR;
    localparam logic [1:0]          c_st_idle = 2'd0;
    localparam logic [1:0]          c_st_exec = 2'd1;
    localparam logic [1:0]          c_st_resp = 2'd2;
    localparam logic [CMD_SIZE-1:0] c_op_add  = CMD_SIZE'(3);

    logic [1:0]           r_state;
    logic [REG_ADDR-1:0]  r_rd;
    logic [WORD_SIZE-1:0] r_regs [c_nregs];
    logic                 r_instr_ready;
    logic                 r_rsp_valid;
    logic [WORD_SIZE-1:0] r_rsp_data;
    logic                 r_rsp_ovf;
    logic [CMD_SIZE-1:0]  r_alu_opcode;
    logic [WORD_SIZE-1:0] r_alu_r1;
    logic [WORD_SIZE-1:0] r_alu_r2;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= c_st_idle;
            r_rd          <= '0;
            r_instr_ready <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_ovf     <= 1'b0;
            r_alu_opcode  <= '0;
            r_alu_r1      <= '0;
            r_alu_r2      <= '0;
            for (int i = 0; i < c_nregs; i++) r_regs[i] <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (instr_valid) begin
                        r_instr_ready <= 1'b0;
                        if (instr_load) begin
                            r_regs[instr_rd] <= instr_imm;
                            r_rsp_data       <= instr_imm;
                            r_rsp_ovf        <= 1'b0;
                            r_rsp_valid      <= 1'b1;
                            r_state          <= c_st_resp;
                        end else begin
                            // Operands captured here, so rd == rs uses the old value
                            r_alu_opcode <= instr_op;
                            r_alu_r1     <= r_regs[instr_rs1];
                            r_alu_r2     <= r_regs[instr_rs2];
                            r_rd         <= instr_rd;
                            r_state      <= c_st_exec;
                        end
                    end
                end
                c_st_exec: begin
                    r_regs[r_rd] <= alu_out;
                    r_rsp_data   <= alu_out;
                    r_rsp_ovf    <= (r_alu_opcode == c_op_add) && alu_ovf;
                    r_rsp_valid  <= 1'b1;
                    r_state      <= c_st_resp;
                end
                c_st_resp: begin
                    if (rsp_ready) begin
                        r_rsp_valid   <= 1'b0;
                        r_instr_ready <= 1'b1;
                        r_state       <= c_st_idle;
                    end
                end
                default: begin
                    r_rsp_valid   <= 1'b0;
                    r_instr_ready <= 1'b1;
                    r_state       <= c_st_idle;
                end
            endcase
        end
    end

    assign instr_ready = r_instr_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign rsp_ovf     = r_rsp_ovf;
    assign alu_opcode  = r_alu_opcode;
    assign alu_r1      = r_alu_r1;
    assign alu_r2      = r_alu_r2;
    assign dbg_data    = r_regs[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_mcpu_alu_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mcpu_alu_sequencer                                                      |
// | Directed and random instruction streams against a transaction-level model.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mcpu_alu_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       instr_valid, instr_ready, instr_load;
    logic [1:0] instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm;
    logic [1:0] alu_opcode, alu_r1, alu_r2, alu_out;
    logic       alu_ovf;
    logic       rsp_valid, rsp_ready, rsp_ovf;
    logic [1:0] rsp_data;
    logic [1:0] dbg_addr, dbg_data;

    always #5 clk = ~clk;

    mcpu_alu_sequencer #(.CMD_SIZE(2), .WORD_SIZE(2), .REG_ADDR(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_load(instr_load),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1),
        .instr_rs2(instr_rs2), .instr_imm(instr_imm),
        .alu_opcode(alu_opcode), .alu_r1(alu_r1), .alu_r2(alu_r2),
        .alu_out(alu_out), .alu_ovf(alu_ovf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_ovf(rsp_ovf),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Stand-in ALU; carry is always driven so ungated overflow would be visible
    logic [2:0] w_sum;
    assign w_sum   = {1'b0, alu_r1} + {1'b0, alu_r2};
    assign alu_ovf = w_sum[2];
    always_comb begin
        alu_out = w_sum[1:0];
        case (alu_opcode)
            2'd0: alu_out = alu_r1 & alu_r2;
            2'd1: alu_out = alu_r1 | alu_r2;
            2'd2: alu_out = alu_r1 ^ alu_r2;
            default: alu_out = w_sum[1:0];
        endcase
    end

    int checks = 0;
    int errors = 0;

    logic       chk_en = 1'b0;
    logic       exp_ready, exp_valid, exp_ovf, alu_chk;
    logic [1:0] exp_data, exp_op, exp_a, exp_b;
    logic [1:0] mregs [4];
    logic [1:0] cap_data;
    logic       cap_ovf;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] ref_op(input logic [1:0] op, input logic [1:0] a, input logic [1:0] b);
        int s;
        s = int'(a) + int'(b);
        case (op)
            2'd0:    return {1'b0, a & b};
            2'd1:    return {1'b0, a | b};
            2'd2:    return {1'b0, a ^ b};
            default: return {(s > 3) ? 1'b1 : 1'b0, 2'(s % 4)};
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("instr_ready", instr_ready, exp_ready);
            chk("rsp_valid", rsp_valid, exp_valid);
            if (exp_valid) begin
                chk("rsp_data", rsp_data, exp_data);
                chk("rsp_ovf", rsp_ovf, exp_ovf);
            end
            chk("dbg_data", dbg_data, mregs[dbg_addr]);
            if (alu_chk) begin
                chk("alu_opcode", alu_opcode, exp_op);
                chk("alu_r1", alu_r1, exp_a);
                chk("alu_r2", alu_r2, exp_b);
            end
        end
        if (rsp_valid) begin
            cap_data = rsp_data;
            cap_ovf  = rsp_ovf;
        end
    end

    initial begin
        dbg_addr = 2'd0;
        forever begin
            @(posedge clk);
            #2;
            dbg_addr = dbg_addr + 2'd1;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic junk_fields();
        instr_load = 1'($urandom);
        instr_op   = 2'($urandom);
        instr_rd   = 2'($urandom);
        instr_rs1  = 2'($urandom);
        instr_rs2  = 2'($urandom);
        instr_imm  = 2'($urandom);
    endtask

    task automatic model_reset();
        exp_ready = 1'b1;
        exp_valid = 1'b0;
        alu_chk   = 1'b0;
        for (int i = 0; i < 4; i++) mregs[i] = 2'd0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            instr_valid = 1'b0;
            junk_fields();
            step();
        end
    endtask

    // Called in IDLE at posedge+2; returns with the response consumed
    task automatic issue(input bit ld, input logic [1:0] op, input logic [1:0] rd,
                         input logic [1:0] rs1, input logic [1:0] rs2, input logic [1:0] imm,
                         input int hold, input bit poke);
        logic [2:0] r;
        instr_valid = 1'b1;
        instr_load  = ld;
        instr_op    = op;
        instr_rd    = rd;
        instr_rs1   = rs1;
        instr_rs2   = rs2;
        instr_imm   = imm;
        step();
        instr_valid = 1'b0;
        junk_fields();
        exp_ready = 1'b0;
        if (ld) begin
            mregs[rd] = imm;
            exp_data  = imm;
            exp_ovf   = 1'b0;
            exp_valid = 1'b1;
        end else begin
            exp_op  = op;
            exp_a   = mregs[rs1];
            exp_b   = mregs[rs2];
            alu_chk = 1'b1;
            step();
            alu_chk   = 1'b0;
            r         = ref_op(exp_op, exp_a, exp_b);
            mregs[rd] = r[1:0];
            exp_data  = r[1:0];
            exp_ovf   = r[2];
            exp_valid = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            rsp_ready = 1'b0;
            if (poke) begin
                instr_valid = 1'b1;
                instr_load  = 1'b1;
                instr_rd    = 2'($urandom);
                instr_imm   = 2'($urandom);
            end
            step();
        end
        instr_valid = 1'b0;
        rsp_ready   = 1'b1;
        step();
        rsp_ready = 1'($urandom);
        exp_valid = 1'b0;
        exp_ready = 1'b1;
    endtask

    initial begin
        reset_n     = 1'b0;
        instr_valid = 1'b0;
        rsp_ready   = 1'b0;
        junk_fields();
        model_reset();
        step();
        chk_en = 1'b1;
        step();
        reset_n = 1'b1;
        idle(4);

        issue(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 0, 1'b0);
        chk("ld_r0", cap_data, 3);
        issue(1'b1, 2'd0, 2'd1, 2'd0, 2'd0, 2'd2, 1, 1'b0);
        chk("ld_r1", cap_data, 2);
        issue(1'b0, 2'd3, 2'd2, 2'd0, 2'd1, 2'd0, 0, 1'b0);
        chk("add_data", cap_data, 1);
        chk("add_ovf", cap_ovf, 1);
        issue(1'b0, 2'd0, 2'd3, 2'd0, 2'd1, 2'd0, 2, 1'b0);
        chk("and_data", cap_data, 2);
        chk("and_ovf", cap_ovf, 0);
        issue(1'b0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd0, 0, 1'b0);
        chk("or_data", cap_data, 3);
        chk("or_ovf", cap_ovf, 0);
        issue(1'b0, 2'd2, 2'd0, 2'd0, 2'd1, 2'd0, 1, 1'b0);
        chk("xor_data", cap_data, 1);
        idle(2);

        // Backpressure with instructions offered while the response is held
        issue(1'b0, 2'd3, 2'd3, 2'd1, 2'd1, 2'd0, 5, 1'b1);
        chk("bp_data", cap_data, 0);
        chk("bp_ovf", cap_ovf, 1);
        idle(1);

        // Reset while the ADD is in its execute cycle
        instr_valid = 1'b1;
        instr_load  = 1'b0;
        instr_op    = 2'd3;
        instr_rd    = 2'd3;
        instr_rs1   = 2'd0;
        instr_rs2   = 2'd1;
        step();
        instr_valid = 1'b0;
        exp_ready   = 1'b0;
        exp_op      = 2'd3;
        exp_a       = mregs[0];
        exp_b       = mregs[1];
        alu_chk     = 1'b1;
        reset_n     = 1'b0;
        step();
        model_reset();
        chk("rst_alu_op", alu_opcode, 0);
        chk("rst_alu_r1", alu_r1, 0);
        step();
        reset_n = 1'b1;
        idle(5);

        for (int n = 0; n < 1000; n++) begin
            issue(($urandom_range(0, 4) == 0), 2'($urandom), 2'($urandom), 2'($urandom),
                  2'($urandom), 2'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
            if ($urandom_range(0, 3) == 0) idle(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
